// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package pipeline_ctrl_pkg;

  localparam int unsigned StopAllW  = 6;
  localparam int unsigned InstAddrW = 32;
  localparam int unsigned WdogW     = 16;

  typedef logic [StopAllW-1:0]  stop_all_t;
  typedef logic [InstAddrW-1:0] inst_addr_t;

  localparam stop_all_t  StopNone   = 6'b000000;
  localparam stop_all_t  StopFromId = 6'b000111;
  localparam stop_all_t  StopFromEx = 6'b001111;
  localparam inst_addr_t ZeroWord   = 32'h0000_0000;

  typedef enum logic {
    CtrlRun   = 1'b0,
    CtrlBlank = 1'b1
  } ctrl_state_e;

  // EX stall stops one stage deeper than an ID stall and dominates it.
  function automatic stop_all_t stop_decode(input logic id_req, input logic ex_req);
    if (ex_req) return StopFromEx;
    if (id_req) return StopFromId;
    return StopNone;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Request/response bundle between the datapath (master) and pipeline_ctrl (slave).
interface pipeline_ctrl_if;
  import pipeline_ctrl_pkg::*;

  logic        stall_request_id;
  logic        stall_request_ex;
  logic        exception_valid;
  logic        exception_is_eret;
  inst_addr_t  cp0_epc;
  stop_all_t   stop_all;
  logic        flush_output;
  inst_addr_t  new_program_counter;
  logic        stall_timeout;
  logic [31:0] stall_cycle_count;

  modport master (
    output stall_request_id, stall_request_ex, exception_valid, exception_is_eret, cp0_epc,
    input  stop_all, flush_output, new_program_counter, stall_timeout, stall_cycle_count
  );

  modport slave (
    input  stall_request_id, stall_request_ex, exception_valid, exception_is_eret, cp0_epc,
    output stop_all, flush_output, new_program_counter, stall_timeout, stall_cycle_count
  );
endinterface

// File: rtl/pipeline_ctrl_stall_watchdog.sv
// Saturating run-length counter of consecutive EX stalls with a sticky timeout flag.
module stall_watchdog
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned STALL_TIMEOUT = 64
) (
  input  logic clock,
  input  logic reset,
  input  logic count_enable,
  input  logic clear,
  output logic timeout
);

  localparam logic [WdogW-1:0] Limit = WdogW'(STALL_TIMEOUT);

  logic [WdogW-1:0] count_q, count_d;
  logic             timeout_q, timeout_d;

  // Flag is raised on the same edge the counter lands on the limit.
  always_comb begin
    count_d   = count_q;
    timeout_d = timeout_q;
    if (clear) begin
      count_d = '0;
    end else if (count_enable && (count_q != Limit)) begin
      count_d = count_q + WdogW'(1);
    end
    if (count_d == Limit) begin
      timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush controller: merges ID/EX stalls, sequences exception/ERET flushes.
// Optional stall profiling counter enabled with PIPELINE_CTRL_PROFILE_EN.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned STALL_TIMEOUT    = 64,
  parameter inst_addr_t  EXCEPTION_VECTOR = 32'h0000_0020
) (
  input  logic             clock,
  input  logic             reset,
  pipeline_ctrl_if.slave   bus
);

  ctrl_state_e state_q, state_d;
  stop_all_t   stop_all_c;
  logic        flush_c;
  inst_addr_t  npc_c;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= CtrlRun;
    end else begin
      state_q <= state_d;
    end
  end

  // An exception in RUN overrides any stall; BLANK masks a repeated exception for one cycle.
  always_comb begin
    state_d    = state_q;
    stop_all_c = stop_decode(bus.stall_request_id, bus.stall_request_ex);
    flush_c    = 1'b0;
    npc_c      = ZeroWord;
    case (state_q)
      CtrlRun: begin
        if (bus.exception_valid) begin
          state_d    = CtrlBlank;
          stop_all_c = StopNone;
          flush_c    = 1'b1;
          npc_c      = bus.exception_is_eret ? bus.cp0_epc : EXCEPTION_VECTOR;
        end
      end
      CtrlBlank: state_d = CtrlRun;
      default:   state_d = CtrlRun;
    endcase
  end

  assign bus.stop_all            = stop_all_c;
  assign bus.flush_output        = flush_c;
  assign bus.new_program_counter = npc_c;

  stall_watchdog #(
    .STALL_TIMEOUT (STALL_TIMEOUT)
  ) u_stall_watchdog (
    .clock        (clock),
    .reset        (reset),
    .count_enable (bus.stall_request_ex & ~flush_c),
    .clear        (~bus.stall_request_ex | flush_c),
    .timeout      (bus.stall_timeout)
  );

`ifdef PIPELINE_CTRL_PROFILE_EN
  logic [31:0] prof_q;

  // Counts every cycle the PC is held, wrapping naturally.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prof_q <= 32'h0;
    end else if (stop_all_c[0]) begin
      prof_q <= prof_q + 32'd1;
    end
  end

  assign bus.stall_cycle_count = prof_q;
`else
  assign bus.stall_cycle_count = 32'h0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: driver queues expectations, negedge monitor checks them.
module tb_pipeline_ctrl;
  import pipeline_ctrl_pkg::*;

  localparam int unsigned Timeout = 4;
  localparam logic [31:0] ExcVec  = 32'h0000_0020;

`ifdef PIPELINE_CTRL_PROFILE_EN
  localparam bit ProfOn = 1'b1;
`else
  localparam bit ProfOn = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  pipeline_ctrl_if bus();

  pipeline_ctrl #(
    .STALL_TIMEOUT    (Timeout),
    .EXCEPTION_VECTOR (ExcVec)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } chk_t;

  chk_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic push(input string name, input int sel, input logic [31:0] exp);
    chk_t e;
    e.name = name;
    e.sel  = sel;
    e.exp  = exp;
    sb_q.push_back(e);
  endtask

  function automatic logic [31:0] actual(input int sel);
    case (sel)
      0:       return 32'(bus.stop_all);
      1:       return 32'(bus.flush_output);
      2:       return bus.new_program_counter;
      3:       return 32'(bus.stall_timeout);
      default: return bus.stall_cycle_count;
    endcase
  endfunction

  chk_t        mon_e;
  logic [31:0] mon_act;

  always @(negedge clock) begin
    while (sb_q.size() > 0) begin
      mon_e   = sb_q.pop_front();
      mon_act = actual(mon_e.sel);
      total++;
      if (mon_act !== mon_e.exp) begin
        bad++;
        $display("FAIL %s: got %h want %h (t=%0t)", mon_e.name, mon_act, mon_e.exp, $time);
      end
    end
  end

  task automatic set_in(input logic id, input logic ex, input logic ev, input logic eret,
                        input logic [31:0] epc);
    bus.stall_request_id  = id;
    bus.stall_request_ex  = ex;
    bus.exception_valid   = ev;
    bus.exception_is_eret = eret;
    bus.cp0_epc           = epc;
  endtask

  task automatic cyc(input string name, input logic id, input logic ex, input logic ev,
                     input logic eret, input logic [31:0] epc, input logic [5:0] es,
                     input logic ef, input logic [31:0] en);
    @(posedge clock);
    #1;
    set_in(id, ex, ev, eret, epc);
    push({name, ".stop"}, 0, 32'(es));
    push({name, ".flush"}, 1, 32'(ef));
    push({name, ".npc"}, 2, en);
  endtask

  task automatic all_zero(input string name);
    push({name, ".stop"}, 0, 32'h0);
    push({name, ".flush"}, 1, 32'h0);
    push({name, ".npc"}, 2, 32'h0);
    push({name, ".tmo"}, 3, 32'h0);
    push({name, ".cnt"}, 4, 32'h0);
  endtask

  initial begin
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

    // Reset held for three cycles, then released with no requests.
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #1;
      all_zero("reset");
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
    all_zero("post_reset");

    // ID stall for two cycles, then ID+EX together.
    cyc("id_stall1", 1, 0, 0, 0, 32'h0, 6'b000111, 0, 32'h0);
    cyc("id_stall2", 1, 0, 0, 0, 32'h0, 6'b000111, 0, 32'h0);
    cyc("id_done",   0, 0, 0, 0, 32'h0, 6'b000000, 0, 32'h0);
    cyc("id_ex",     1, 1, 0, 0, 32'h0, 6'b001111, 0, 32'h0);
    cyc("idle1",     0, 0, 0, 0, 32'h0, 6'b000000, 0, 32'h0);

    // Exception held two cycles: one flush, second cycle is BLANK.
    cyc("exc",       0, 0, 1, 0, 32'hDEAD_BEEF, 6'b000000, 1, ExcVec);
    cyc("exc_held",  0, 0, 1, 0, 32'hDEAD_BEEF, 6'b000000, 0, 32'h0);
    cyc("exc_again", 0, 0, 1, 0, 32'h0, 6'b000000, 1, ExcVec);
    cyc("blank_id",  1, 0, 1, 1, 32'h0000_0ABC, 6'b000111, 0, 32'h0);
    cyc("idle2",     0, 0, 0, 0, 32'h0, 6'b000000, 0, 32'h0);

    // ERET together with an EX stall: flush wins, stall dropped.
    cyc("eret_ex",   0, 1, 1, 1, 32'h0000_1234, 6'b000000, 1, 32'h0000_1234);
    cyc("eret_blank",0, 1, 0, 0, 32'h0, 6'b001111, 0, 32'h0);
    cyc("idle3",     0, 0, 0, 0, 32'h0, 6'b000000, 0, 32'h0);

    // Reset pulsed inside BLANK: state returns to RUN at once, so the held exception flushes again.
    cyc("exc_pre_rst", 0, 0, 1, 0, 32'h0, 6'b000000, 1, ExcVec);
    @(posedge clock);
    #1;
    reset = 1'b1;
    #2;
    reset = 1'b0;
    push("rst_in_blank.flush", 1, 32'h1);
    push("rst_in_blank.npc", 2, ExcVec);
    cyc("after_rst_blank", 0, 0, 0, 0, 32'h0, 6'b000000, 0, 32'h0);

    // Watchdog: 3 EX stalls, gap, 4 EX stalls -> timeout after the fourth.
    for (int i = 0; i < 3; i++) begin
      cyc("wd_a", 0, 1, 0, 0, 32'h0, 6'b001111, 0, 32'h0);
      push("wd_a.tmo", 3, 32'h0);
    end
    cyc("wd_gap", 0, 0, 0, 0, 32'h0, 6'b000000, 0, 32'h0);
    push("wd_gap.tmo", 3, 32'h0);
    for (int i = 0; i < 4; i++) begin
      cyc("wd_b", 0, 1, 0, 0, 32'h0, 6'b001111, 0, 32'h0);
      push("wd_b.tmo", 3, 32'h0);
    end
    cyc("wd_trip", 0, 0, 0, 0, 32'h0, 6'b000000, 0, 32'h0);
    push("wd_trip.tmo", 3, 32'h1);
    cyc("wd_sticky", 1, 0, 0, 0, 32'h0, 6'b000111, 0, 32'h0);
    push("wd_sticky.tmo", 3, 32'h1);

    // Reset pulsed mid-stall with EX still requesting clears the flag and counter.
    for (int i = 0; i < 3; i++) begin
      cyc("wd_c", 0, 1, 0, 0, 32'h0, 6'b001111, 0, 32'h0);
      push("wd_c.tmo", 3, 32'h1);
    end
    @(posedge clock);
    #1;
    reset = 1'b1;
    #2;
    reset = 1'b0;
    push("wd_rst.stop", 0, 32'(StopFromEx));
    push("wd_rst.tmo", 3, 32'h0);
    push("wd_rst.cnt", 4, 32'h0);
    cyc("wd_after_rst", 0, 0, 0, 0, 32'h0, 6'b000000, 0, 32'h0);
    push("wd_after_rst.tmo", 3, 32'h0);

    // Profiling: 5 EX-stall cycles plus 2 ID-stall cycles.
    @(posedge clock);
    #1;
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    reset = 1'b1;
    all_zero("prof_rst");
    @(posedge clock);
    #1;
    reset = 1'b0;
    all_zero("prof_rel");
    for (int i = 0; i < 5; i++) begin
      cyc("prof_ex", 0, 1, 0, 0, 32'h0, 6'b001111, 0, 32'h0);
    end
    cyc("prof_id1", 1, 0, 0, 0, 32'h0, 6'b000111, 0, 32'h0);
    push("prof_mid.cnt", 4, ProfOn ? 32'd5 : 32'd0);
    cyc("prof_id2", 1, 0, 0, 0, 32'h0, 6'b000111, 0, 32'h0);
    cyc("prof_end", 0, 0, 0, 0, 32'h0, 6'b000000, 0, 32'h0);
    push("prof_end.cnt", 4, ProfOn ? 32'd7 : 32'd0);
    cyc("prof_hold", 0, 0, 1, 0, 32'h0, 6'b000000, 1, ExcVec);
    push("prof_hold.cnt", 4, ProfOn ? 32'd7 : 32'd0);

    @(negedge clock);
    #1;
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL sim_time_limit: got expired want finished");
    $fatal(1);
  end

endmodule
